// File: rtl/att_pkg.sv
// Shared types and default parameters for the attenuator serial back-end.
package att_pkg;

    typedef enum logic [2:0] {IDLE, SHIFT, TAIL, LATCH, SETTLE} att_state_t;

    localparam int unsigned ATT_DATA_W     = 16;
    localparam int unsigned ATT_CLK_DIV    = 5;
    localparam int unsigned ATT_LE_WIDTH   = 2;
    localparam int unsigned ATT_SETTLE_CYC = 4000;

endpackage

// File: rtl/att_phase_cnt.sv
// Half-period divider for the serial clock: ticks on the last aclk cycle of each
// half-period and toggles the half (low/high) flag on that tick.
module att_phase_cnt
    import att_pkg::*;
#(
    parameter int unsigned CLK_DIV = ATT_CLK_DIV
) (
    input  logic aclk,
    input  logic areset,
    input  logic clr,
    input  logic en,
    output logic tick,
    output logic half,
    output logic half_nxt
);

    localparam int unsigned PH_W = $clog2(CLK_DIV + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

    logic [PH_W-1:0] cnt_q, cnt_d;
    logic            half_q, half_d;

    assign tick     = en && (cnt_q == PH_LAST);
    assign half     = half_q;
    assign half_nxt = half_d;

    always_comb begin
        cnt_d  = cnt_q;
        half_d = half_q;
        if (clr) begin
            cnt_d  = '0;
            half_d = 1'b0;
        end else if (en) begin
            if (tick) begin
                cnt_d  = '0;
                half_d = ~half_q;
            end else begin
                cnt_d = cnt_q + PH_W'(1);
            end
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q  <= '0;
            half_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            half_q <= half_d;
        end
    end

endmodule

// File: rtl/att_serial_shifter.sv
// Serial back-end of the AXI attenuator: accepts one word, shifts it LSB-first on
// att_si/att_clk, pulses att_le, then holds busy through the chip settling time.
module att_serial_shifter
    import att_pkg::*;
#(
    parameter int unsigned DATA_W     = ATT_DATA_W,
    parameter int unsigned CLK_DIV    = ATT_CLK_DIV,
    parameter int unsigned LE_WIDTH   = ATT_LE_WIDTH,
    parameter int unsigned SETTLE_CYC = ATT_SETTLE_CYC
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              busy,
    output logic              done,
    output logic              att_clk,
    output logic              att_si,
    output logic              att_le
);

    localparam int unsigned BIT_W = $clog2(DATA_W + 1);
    localparam int unsigned LE_W  = $clog2(LE_WIDTH + 1);
    localparam int unsigned SET_W = $clog2(SETTLE_CYC + 1);

    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [LE_W-1:0]  LE_LAST  = LE_W'(LE_WIDTH - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    att_state_t        state_q, state_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [LE_W-1:0]   le_cnt_q, le_cnt_d;
    logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic              att_clk_q, att_clk_d;
    logic              att_si_q, att_si_d;
    logic              att_le_q, att_le_d;
    logic              done_q, done_d;

    logic ph_tick, ph_half, ph_half_nxt, ph_clr, ph_en;
    logic accept, bit_end, entry;

    assign s_ready = (state_q == IDLE);
    assign busy    = (state_q != IDLE);
    assign att_clk = att_clk_q;
    assign att_si  = att_si_q;
    assign att_le  = att_le_q;
    assign done    = done_q;

    assign accept  = s_valid && (state_q == IDLE);
    assign bit_end = (state_q == SHIFT) && ph_tick && ph_half;
    assign entry   = (state_d != state_q);
    assign ph_clr  = entry;
    assign ph_en   = (state_q == SHIFT) || (state_q == TAIL);

    att_phase_cnt #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_cnt (
        .aclk     (aclk),
        .areset   (areset),
        .clr      (ph_clr),
        .en       (ph_en),
        .tick     (ph_tick),
        .half     (ph_half),
        .half_nxt (ph_half_nxt)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (s_valid) state_d = SHIFT;
            SHIFT:   if (bit_end && (bit_cnt_q == BIT_LAST)) state_d = TAIL;
            TAIL:    if (ph_tick) state_d = LATCH;
            LATCH:   if (le_cnt_q == LE_LAST) state_d = SETTLE;
            SETTLE:  if (settle_cnt_q == SET_LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Counters restart on every state entry, so none ever runs past its last value.
    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        le_cnt_d     = le_cnt_q;
        settle_cnt_d = settle_cnt_q;
        shreg_d      = shreg_q;
        if (entry) begin
            bit_cnt_d    = '0;
            le_cnt_d     = '0;
            settle_cnt_d = '0;
        end else begin
            if (bit_end)             bit_cnt_d    = bit_cnt_q + BIT_W'(1);
            if (state_q == LATCH)    le_cnt_d     = le_cnt_q + LE_W'(1);
            if (state_q == SETTLE)   settle_cnt_d = settle_cnt_q + SET_W'(1);
        end
        if (accept) begin
            shreg_d = s_data;
        end else if (bit_end) begin
            shreg_d = shreg_q >> 1;
        end
    end

    // Chip outputs are registered from next-state values so they line up with the state.
    always_comb begin
        att_clk_d = (state_d == SHIFT) && ph_half_nxt;
        att_si_d  = (state_d == SHIFT) && shreg_d[0];
        att_le_d  = (state_d == LATCH);
        done_d    = (state_d == SETTLE) && (settle_cnt_d == SET_LAST);
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            le_cnt_q     <= '0;
            settle_cnt_q <= '0;
            shreg_q      <= '0;
            att_clk_q    <= 1'b0;
            att_si_q     <= 1'b0;
            att_le_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            le_cnt_q     <= le_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            shreg_q      <= shreg_d;
            att_clk_q    <= att_clk_d;
            att_si_q     <= att_si_d;
            att_le_q     <= att_le_d;
            done_q       <= done_d;
        end
    end

endmodule
